// File: rtl/shift_seq_sfr.sv
// Multi-mode shift SFR: parallel load, single-step shifts, and counted
// multi-bit shifts driven by a start/busy/done handshake.
module shift_seq_sfr #(
  parameter int SIZE  = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [SIZE-1:0]  D,
  input  logic             start,
  input  logic             left,
  input  logic             right,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [SIZE-1:0]  Q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  // Handshake: start is taken only in IDLE. busy stays high while steps remain,
  // and done pulses for one cycle alongside the final Q. ld aborts without done.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [AMT_W-1:0] count;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [SIZE:0]    l_step, r_step, s_step;

  // Returns {bit shifted out, next register value} for one step.
  function automatic logic [SIZE:0] shift_step(input logic [SIZE-1:0] q,
                                               input logic to_right,
                                               input logic [1:0] m,
                                               input logic s);
    logic fill;
    fill = 1'b0;
    if (!to_right) begin
      case (m)
        2'b10:   fill = q[SIZE-1];
        2'b11:   fill = s;
        default: fill = 1'b0;
      endcase
      return {q[SIZE-1], q[SIZE-2:0], fill};
    end else begin
      case (m)
        2'b01:   fill = q[SIZE-1];
        2'b10:   fill = q[0];
        2'b11:   fill = s;
        default: fill = 1'b0;
      endcase
      return {q[0], fill, q[SIZE-1:1]};
    end
  endfunction

  always_comb begin
    l_step = shift_step(Q, 1'b0, mode, sin);
    r_step = shift_step(Q, 1'b1, mode, sin);
    s_step = shift_step(Q, dir_q, mode_q, sin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      Q      <= '0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld) begin
            Q    <= D;
            sout <= 1'b0;
          end else if (start) begin
            dir_q  <= dir;
            mode_q <= mode;
            count  <= amt;
            if (amt == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end else if (left) begin
            {sout, Q} <= l_step;
          end else if (right) begin
            {sout, Q} <= r_step;
          end
        end
        SHIFT: begin
          if (ld) begin
            Q     <= D;
            sout  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            {sout, Q} <= s_step;
            count     <= count - AMT_W'(1);
            if (count == AMT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero = (Q == '0);

endmodule
